// File: rtl/ft_tx_scheduler.sv
// ft_tx_scheduler
//   Packet scheduler for the FTDI upstream link. It arbitrates between the IQ
//   sample FIFO and CPU-written blocks, and grants one packet at a time. For
//   each packet it builds the header word and counts payload words against
//   the FTDI read strobe. It drives the source read strobes and the output-mux
//   word select.
//
// Handshake: re_i is the only transfer qualifier. A word moves in exactly the
//   cycles where re_i=1 and the block is in HDR or PAY. sel_o tells the output
//   mux which word is on offer. fifo_re_o and cpu_re_o are combinational
//   echoes of re_i for the granted source. With re_i=0 nothing advances.
//
// Ports
//   clk_i           FTDI-domain clock (only clock)
//   reset_n         synchronous reset, active-low
//   enable_i        permits new grants; a packet in progress always completes
//   re_i            FTDI accepted the current word this cycle
//   fifo_enough_i   IQ FIFO holds at least one packet
//   fifo_empty_i    IQ FIFO empty (payload word becomes zero pad)
//   fifo_urgent_i   IQ FIFO near overflow; overrides CPU priority
//   cpu_blkcnt_i    CPU blocks written, wraps mod 16
//   fifo_re_o       IQ FIFO read strobe
//   cpu_re_o        CPU buffer read strobe
//   sel_o           0 idle, 1 header, 2 source payload, 3 zero pad
//   hdr_o           header {type[3:0], seq[11:0], len[15:0]}
//   busy_o          high in HDR and PAY
//   cpu_blk_done_o  one-cycle pulse after a CPU packet completes
//   underrun_o      saturating count of padded IQ words
//   dbg_state       FSM state (0 IDLE, 1 HDR, 2 PAY) for observation
module ft_tx_scheduler #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int IQ_PKT_WORDS  = 4096,
    parameter int CPU_PKT_WORDS = 256,
    parameter int CPU_BURST_MAX = 2,
    parameter int SEQ_WIDTH     = 12
) (
    input  logic                     clk_i,
    input  logic                     reset_n,
    input  logic                     enable_i,
    input  logic                     re_i,
    input  logic                     fifo_enough_i,
    input  logic                     fifo_empty_i,
    input  logic                     fifo_urgent_i,
    input  logic [3:0]               cpu_blkcnt_i,
    output logic                     fifo_re_o,
    output logic                     cpu_re_o,
    output logic [1:0]               sel_o,
    output logic [FT_DATA_WIDTH-1:0] hdr_o,
    output logic                     busy_o,
    output logic                     cpu_blk_done_o,
    output logic [15:0]              underrun_o,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    localparam logic       SRC_IQ  = 1'b0;
    localparam logic       SRC_CPU = 1'b1;
    localparam logic [15:0] IQ_LEN  = 16'(IQ_PKT_WORDS);
    localparam logic [15:0] CPU_LEN = 16'(CPU_PKT_WORDS);
    localparam int          CW      = $clog2(CPU_BURST_MAX + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(CPU_BURST_MAX);

    state_t                   state_q, state_d;
    logic                     src_q;
    logic [FT_DATA_WIDTH-1:0] hdr_q;
    logic [15:0]              len_q;
    logic [15:0]              word_cnt;
    logic [SEQ_WIDTH-1:0]     seq_iq, seq_cpu;
    logic [3:0]               cpu_done_cnt;
    logic [CW-1:0]            cpu_consec;
    logic [15:0]              underrun_q;
    logic                     blk_done_q;

    logic cpu_pending;
    logic grant;
    logic grant_src;
    logic last_word;
    logic pad;

    function automatic logic [FT_DATA_WIDTH-1:0] make_hdr(
        input logic [3:0]           kind,
        input logic [SEQ_WIDTH-1:0] seq,
        input logic [15:0]          len
    );
        return FT_DATA_WIDTH'({kind, 12'(seq), len});
    endfunction

    // Arbitration. The 4-bit inequality stays correct across the mod-16 wrap
    // of cpu_blkcnt_i, as long as no more than 15 blocks are outstanding.
    always_comb begin
        cpu_pending = (cpu_done_cnt != cpu_blkcnt_i);
        grant       = 1'b0;
        grant_src   = SRC_IQ;
        if (fifo_urgent_i && fifo_enough_i) begin
            grant     = 1'b1;
            grant_src = SRC_IQ;
        end else if (cpu_pending && (cpu_consec < BURST_MAX)) begin
            grant     = 1'b1;
            grant_src = SRC_CPU;
        end else if (fifo_enough_i) begin
            grant     = 1'b1;
            grant_src = SRC_IQ;
        end else if (cpu_pending) begin
            grant     = 1'b1;
            grant_src = SRC_CPU;
        end
        if (!enable_i) begin
            grant = 1'b0;
        end
    end

    assign last_word = (word_cnt == (len_q - 16'd1));

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_o     = 2'd0;
        fifo_re_o = 1'b0;
        cpu_re_o  = 1'b0;
        pad       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                sel_o = 2'd1;
                if (re_i) begin
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                pad       = (src_q == SRC_IQ) && fifo_empty_i;
                sel_o     = pad ? 2'd3 : 2'd2;
                fifo_re_o = re_i && (src_q == SRC_IQ) && !fifo_empty_i;
                cpu_re_o  = re_i && (src_q == SRC_CPU);
                if (re_i && last_word) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            src_q        <= SRC_IQ;
            hdr_q        <= '0;
            len_q        <= '0;
            word_cnt     <= '0;
            seq_iq       <= '0;
            seq_cpu      <= '0;
            cpu_done_cnt <= '0;
            cpu_consec   <= '0;
            underrun_q   <= '0;
            blk_done_q   <= 1'b0;
        end else begin
            blk_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        src_q <= grant_src;
                        if (grant_src == SRC_CPU) begin
                            hdr_q   <= make_hdr(4'h2, seq_cpu, CPU_LEN);
                            len_q   <= CPU_LEN;
                            seq_cpu <= seq_cpu + SEQ_WIDTH'(1);
                            // Saturating: only the comparison against the
                            // burst limit matters.
                            if (cpu_consec < BURST_MAX) begin
                                cpu_consec <= cpu_consec + CW'(1);
                            end
                        end else begin
                            hdr_q      <= make_hdr(4'h1, seq_iq, IQ_LEN);
                            len_q      <= IQ_LEN;
                            seq_iq     <= seq_iq + SEQ_WIDTH'(1);
                            cpu_consec <= '0;
                        end
                    end
                end
                ST_HDR: begin
                    if (re_i) begin
                        word_cnt <= '0;
                    end
                end
                ST_PAY: begin
                    if (re_i) begin
                        if (pad && (underrun_q != 16'hFFFF)) begin
                            underrun_q <= underrun_q + 16'd1;
                        end
                        if (last_word) begin
                            // The done count is updated on the same edge that
                            // re-enters IDLE, so the first IDLE cycle already
                            // arbitrates on the retired block.
                            if (src_q == SRC_CPU) begin
                                cpu_done_cnt <= cpu_done_cnt + 4'd1;
                                blk_done_q   <= 1'b1;
                            end
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hdr_o          = hdr_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign cpu_blk_done_o = blk_done_q;
    assign underrun_o     = underrun_q;
    assign dbg_state      = state_q;

endmodule
